// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - interval-timer register map, control words and sequencer states
package timer_pkg;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;

  localparam int STAT_TO_BIT    = 0;
  localparam int STAT_RUN_BIT   = 1;
  localparam int CTRL_ITO_BIT   = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;

  localparam logic [15:0] CTRL_RUN_IRQ = 16'h0007;
  localparam logic [15:0] CTRL_STOP    = 16'h0008;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTRL,
    RD_STAT,
    CHK_STAT,
    WAIT_IRQ,
    CLR_TO,
    STEP,
    WR_STOP
  } seq_state_t;

endpackage

// File: rtl/led_bounce.sv
// rtl/led_bounce.sv - one-hot LED pattern that bounces between both ends on each step
module led_bounce #(
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  output logic [LED_W-1:0] led
);

  logic down;

  // Direction flips on the step that lands on an end bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led  <= {{(LED_W-1){1'b0}}, 1'b1};
      down <= 1'b0;
    end else if (step) begin
      if (!down) begin
        led <= led << 1;
        if (led[LED_W-2]) down <= 1'b1;
      end else begin
        led <= led >> 1;
        if (led[1]) down <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/timer_light_sequencer.sv
// rtl/timer_light_sequencer.sv - bus master that programs the interval timer and steps LEDs on timeout
module timer_light_sequencer
  import timer_pkg::*;
#(
  parameter int          LED_W          = 8,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd49999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [31:0]      cfg_period,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic [15:0]      tmr_readdata,
  input  logic             tmr_irq,
  output logic [LED_W-1:0] led,
  output logic [15:0]      step_count,
  output logic             busy,
  output logic             start_err
);

  seq_state_t  state;
  logic [31:0] period_reg;
  logic [31:0] pend_period;
  logic [31:0] start_period;
  logic        pend;
  logic        step;
  logic        unused_rd;

  assign busy      = (state != IDLE);
  assign step      = (state == STEP);
  assign unused_rd = ^{tmr_readdata[15:2], tmr_readdata[STAT_TO_BIT]};

  // Period used when leaving IDLE: a same-cycle load beats a retained pending one.
  always_comb begin
    start_period = period_reg;
    if (cfg_load)  start_period = cfg_period;
    else if (pend) start_period = pend_period;
  end

  // Bus outputs are loaded on entry to each state, so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      period_reg     <= DEFAULT_PERIOD;
      pend_period    <= 32'd0;
      pend           <= 1'b0;
      step_count     <= 16'd0;
      start_err      <= 1'b0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= 3'd0;
      tmr_writedata  <= 16'd0;
    end else begin
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      case (state)
        IDLE: if (enable) begin
          period_reg     <= start_period;
          pend           <= 1'b0;
          state          <= WR_PL;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= TMR_PERIODL;
          tmr_writedata  <= start_period[15:0];
        end
        WR_PL: begin
          state          <= WR_PH;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= TMR_PERIODH;
          tmr_writedata  <= period_reg[31:16];
        end
        WR_PH: begin
          state          <= WR_CTRL;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= TMR_CONTROL;
          tmr_writedata  <= CTRL_RUN_IRQ;
        end
        WR_CTRL: begin
          state          <= RD_STAT;
          tmr_chipselect <= 1'b1;
          tmr_address    <= TMR_STATUS;
        end
        RD_STAT: state <= CHK_STAT;
        CHK_STAT: begin
          if (tmr_readdata[STAT_RUN_BIT]) begin
            state <= WAIT_IRQ;
          end else begin
            start_err      <= 1'b1;
            state          <= WR_CTRL;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= TMR_CONTROL;
            tmr_writedata  <= CTRL_RUN_IRQ;
          end
        end
        WAIT_IRQ: begin
          if (!enable) begin
            state          <= WR_STOP;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= TMR_CONTROL;
            tmr_writedata  <= CTRL_STOP;
          end else if (pend) begin
            period_reg     <= pend_period;
            pend           <= 1'b0;
            state          <= WR_PL;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= TMR_PERIODL;
            tmr_writedata  <= pend_period[15:0];
          end else if (tmr_irq) begin
            state          <= CLR_TO;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= TMR_STATUS;
            tmr_writedata  <= 16'h0000;
          end
        end
        CLR_TO: state <= STEP;
        // STEP doubles as the cycle that lets irq fall after the status write.
        STEP: begin
          step_count <= step_count + 16'd1;
          state      <= WAIT_IRQ;
        end
        WR_STOP: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (cfg_load) begin
        if (state == IDLE) begin
          period_reg <= cfg_period;
          pend       <= 1'b0;
        end else begin
          pend_period <= cfg_period;
          pend        <= 1'b1;
        end
      end
    end
  end

  led_bounce #(.LED_W(LED_W)) u_led_bounce (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (step),
    .led     (led)
  );

endmodule

// File: tb/tb_timer_light_sequencer.sv
// tb/tb_timer_light_sequencer.sv - directed bench with an interval-timer slave model
module tb_timer_light_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        cfg_load;
  logic [31:0] cfg_period;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;
  logic [7:0]  led;
  logic [15:0] step_count;
  logic        busy;
  logic        start_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  timer_light_sequencer #(.LED_W(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .cfg_load       (cfg_load),
    .cfg_period     (cfg_period),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_readdata   (tmr_readdata),
    .tmr_irq        (tmr_irq),
    .led            (led),
    .step_count     (step_count),
    .busy           (busy),
    .start_err      (start_err)
  );

  // Interval-timer slave model
  logic [15:0] per_l, per_h;
  logic [31:0] cnt;
  logic        t_to, t_run, t_ito, t_cont;
  int          stat_reads;
  int          run0_at;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_l <= 16'd0; per_h <= 16'd0; cnt <= 32'd0;
      t_to <= 1'b0; t_run <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0;
      tmr_irq <= 1'b0; tmr_readdata <= 16'd0; stat_reads <= 0;
    end else begin
      if (t_run) begin
        if (cnt == 32'd0) begin
          t_to <= 1'b1;
          cnt  <= {per_h, per_l};
          if (!t_cont) t_run <= 1'b0;
        end else begin
          cnt <= cnt - 32'd1;
        end
      end
      tmr_irq <= t_to & t_ito;
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito  <= tmr_writedata[0];
            t_cont <= tmr_writedata[1];
            if (tmr_writedata[2]) t_run <= 1'b1;
            if (tmr_writedata[3]) t_run <= 1'b0;
          end
          3'd2: begin per_l <= tmr_writedata; t_run <= 1'b0; cnt <= {per_h, tmr_writedata}; end
          3'd3: begin per_h <= tmr_writedata; t_run <= 1'b0; cnt <= {tmr_writedata, per_l}; end
          default: ;
        endcase
      end
      if (tmr_chipselect && tmr_write_n) begin
        if (tmr_address == 3'd0) begin
          tmr_readdata <= {14'd0, t_run && (stat_reads != run0_at), t_to};
          stat_reads   <= stat_reads + 1;
        end else begin
          tmr_readdata <= 16'd0;
        end
      end
    end
  end

  // Bus and irq logs
  int          cyc = 0;
  logic        irq_prev = 1'b0;
  logic [2:0]  wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];
  int          rc_q[$];
  int          irq_t[$];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    irq_prev <= tmr_irq;
    if (reset_n && tmr_chipselect && !tmr_write_n) begin
      wa_q.push_back(tmr_address);
      wd_q.push_back(tmr_writedata);
      wc_q.push_back(cyc);
    end
    if (reset_n && tmr_chipselect && tmr_write_n) rc_q.push_back(cyc);
    if (tmr_irq && !irq_prev) irq_t.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] led_exp(input int k);
    int i;
    int p;
    logic [7:0] one;
    i   = k % 14;
    p   = (i <= 7) ? i : 14 - i;
    one = 8'd1;
    return one << p;
  endfunction

  task automatic wait_steps(input int n);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (step_count == 16'(n)) break;
    end
    chk("steps", {16'd0, step_count}, n);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle", {31'd0, busy}, 0);
  endtask

  task automatic chk_prog(input string tag, input int m, input logic [15:0] lo);
    chk({tag, "_n"}, 32'(wa_q.size() >= m + 3), 1);
    if (wa_q.size() >= m + 3) begin
      chk({tag, "_pl"}, {13'd0, wa_q[m], wd_q[m]}, {13'd2, lo});
      chk({tag, "_ph"}, {13'd0, wa_q[m+1], wd_q[m+1]}, {13'd3, 16'h0000});
      chk({tag, "_ct"}, {13'd0, wa_q[m+2], wd_q[m+2]}, {13'd1, 16'h0007});
    end
  endtask

  initial begin
    int m, j, n0, s, n17;
    reset_n = 1'b0; enable = 1'b0; cfg_load = 1'b0; cfg_period = 32'd0; run0_at = -1;
    repeat (3) @(negedge clk);
    chk("rst_led", {24'd0, led}, 32'h01);
    chk("rst_steps", {16'd0, step_count}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_err", {31'd0, start_err}, 0);
    chk("rst_bus", {29'd0, tmr_chipselect, tmr_write_n, 1'b0}, 32'h2);
    chk("rst_addr", {13'd0, tmr_address, tmr_writedata}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: default period programming
    enable = 1'b1;
    repeat (6) @(negedge clk);
    chk_prog("dflt", 0, 16'hC34F);
    if (wc_q.size() >= 3) begin
      chk("dflt_seq", wc_q[2] - wc_q[0], 2);
      chk("dflt_rd", rc_q.size(), 1);
      if (rc_q.size() >= 1) chk("dflt_rdcyc", rc_q[0], wc_q[2] + 1);
    end
    chk("dflt_busy", {31'd0, busy}, 1);
    chk("dflt_err", {31'd0, start_err}, 0);
    enable = 1'b0;
    wait_idle();

    // 2: period 4 loaded in IDLE
    cfg_load = 1'b1; cfg_period = 32'd4;
    @(negedge clk);
    cfg_load = 1'b0; enable = 1'b1;
    n0 = irq_t.size();
    m  = wa_q.size();
    for (int k = 1; k <= 3; k++) begin
      wait_steps(k);
      chk("p4_led", {24'd0, led}, {24'd0, led_exp(k)});
    end
    chk("p4_irqs", irq_t.size() - n0, 3);
    if (irq_t.size() >= n0 + 3) chk("p4_space", irq_t[n0+2] - irq_t[n0+1], 5);
    j = 0;
    for (int i = m; i < wa_q.size(); i++) if (wa_q[i] == 3'd0 && wd_q[i] == 16'h0) j++;
    chk("p4_clr", j, 3);

    // 3: bounce through 0x80 and back to 0x01
    for (int k = 4; k <= 16; k++) begin
      wait_steps(k);
      chk("bounce_led", {24'd0, led}, {24'd0, led_exp(k)});
    end

    // 4: reprogram to period 9 while running
    m = wa_q.size();
    cfg_load = 1'b1; cfg_period = 32'd9;
    @(negedge clk);
    cfg_load = 1'b0;
    j = -1;
    for (int c = 0; c < 60 && j < 0; c++) begin
      @(negedge clk);
      for (int i = m; i + 2 < wa_q.size(); i++)
        if (j < 0 && wa_q[i] == 3'd2 && wa_q[i+2] == 3'd1) j = i;
    end
    chk("rp_found", 32'(j >= 0), 1);
    if (j >= 0) chk_prog("rp", j, 16'h0009);
    n0 = irq_t.size();
    for (int c = 0; c < 100 && irq_t.size() < n0 + 3; c++) @(negedge clk);
    chk("rp_irqs", 32'(irq_t.size() >= n0 + 3), 1);
    if (irq_t.size() >= n0 + 3) chk("rp_space", irq_t[n0+2] - irq_t[n0+1], 10);

    // 5: stop from WAIT_IRQ, LEDs frozen, restart
    s = int'(step_count);
    n17 = s + 1;
    wait_steps(n17);
    chk("pre_stop_led", {24'd0, led}, {24'd0, led_exp(n17)});
    enable = 1'b0;
    m = wa_q.size();
    repeat (6) @(negedge clk);
    chk("stop_n", wa_q.size() - m, 1);
    if (wa_q.size() > m) chk("stop_wr", {13'd0, wa_q[m], wd_q[m]}, {13'd1, 16'h0008});
    chk("stop_busy", {31'd0, busy}, 0);
    repeat (40) @(negedge clk);
    chk("frz_steps", {16'd0, step_count}, n17);
    chk("frz_led", {24'd0, led}, {24'd0, led_exp(n17)});
    m = wa_q.size();
    enable = 1'b1;
    repeat (6) @(negedge clk);
    chk_prog("restart", m, 16'h0009);

    // 6: RUN=0 on first status read
    enable = 1'b0;
    wait_idle();
    run0_at = stat_reads;
    m = wa_q.size();
    enable = 1'b1;
    repeat (12) @(negedge clk);
    chk("serr_set", {31'd0, start_err}, 1);
    j = 0;
    for (int i = m; i < wa_q.size(); i++) if (wa_q[i] == 3'd1 && wd_q[i] == 16'h0007) j++;
    chk("serr_ctrl", j, 2);
    chk("serr_busy", {31'd0, busy}, 1);
    repeat (30) @(negedge clk);
    chk("serr_stick", {31'd0, start_err}, 1);

    reset_n = 1'b0;
    #2;
    chk("arst_err", {31'd0, start_err}, 0);
    chk("arst_led", {24'd0, led}, 32'h01);
    chk("arst_steps", {16'd0, step_count}, 0);
    chk("arst_cs", {31'd0, tmr_chipselect}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
